// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline controller: FSM state encoding,
// the per-stage control bundle with its idle value, and counter width.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  localparam int unsigned SAT_CNT_W = 16;

  // One bundle for every pipeline-register control, so overrides stay compact.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exma_en;
    logic exma_bubble;
    logic mawb_bubble;
    logic halt_ack;
  } ctrl_t;

  // Normal flow: every stage advances, no NOPs inserted.
  localparam ctrl_t CTRL_DEFAULT = '{
    pc_en:       1'b1,
    ifid_en:     1'b1,
    ifid_flush:  1'b0,
    idex_en:     1'b1,
    idex_flush:  1'b0,
    exma_en:     1'b1,
    exma_bubble: 1'b0,
    mawb_bubble: 1'b0,
    halt_ack:    1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges hazard, multi-cycle, memory-wait and
// halt requests into per-stage enable/flush/bubble controls for the 5-stage core.
module pipe_stall_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MC_LATENCY   = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = SAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             dmem_wait,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exma_en,
  output logic             exma_bubble,
  output logic             mawb_bubble,
  output logic             halt_ack,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MC_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  state_e          state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [DC_W-1:0] drain_q, drain_d;
  logic            ret_drain_q, ret_drain_d;
  logic            lu_stall, lu_stall_q;
  logic            flush_inc, stall_inc;
  logic            draining;
  ctrl_t           ctrl;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    ctrl        = CTRL_DEFAULT;
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    drain_d     = drain_q;
    ret_drain_d = ret_drain_q;
    flush_inc   = 1'b0;
    lu_stall    = 1'b0;
    draining    = (state_q == ST_DRAIN);

    if (state_q == ST_HALTED) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
      ctrl.halt_ack   = 1'b1;
      if (!halt_req) state_d = ST_RUN;
    end else if (dmem_wait) begin
      // Freeze everything up to MA; WB gets a NOP while the access completes.
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exma_en     = 1'b0;
      ctrl.mawb_bubble = 1'b1;
    end else if (state_q == ST_MC_WAIT) begin
      if (mc_cnt_q != '0) begin
        ctrl.pc_en       = 1'b0;
        ctrl.ifid_en     = 1'b0;
        ctrl.idex_en     = 1'b0;
        ctrl.exma_bubble = 1'b1;
        mc_cnt_d         = mc_cnt_q - 1'b1;
      end else begin
        // Release cycle; when resuming a drain, keep the PC parked.
        state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
        if (ret_drain_q) begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_flush = 1'b1;
        end
      end
    end else if (mc_start) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exma_bubble = 1'b1;
      mc_cnt_d         = MC_W'(MC_LATENCY - 2);
      ret_drain_d      = draining;
      state_d          = ST_MC_WAIT;
    end else begin
      if (draining) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_flush = 1'b1;
      end
      if (branch_taken) begin
        // Load-use consumer is flushed along with the wrong-path fetch.
        ctrl.pc_en      = 1'b1;
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        flush_inc       = 1'b1;
      end else if (load_use) begin
        ctrl.pc_en       = 1'b0;
        ctrl.ifid_en     = 1'b0;
        ctrl.ifid_flush  = 1'b0;
        ctrl.idex_en     = 1'b0;
        ctrl.exma_bubble = 1'b1;
        lu_stall         = 1'b1;
      end

      if (draining) begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else if (!lu_stall) begin
          drain_d = drain_q - 1'b1;
          if (drain_q == DC_W'(1)) state_d = ST_HALTED;
        end
      end else if (halt_req && !branch_taken && !load_use) begin
        state_d = ST_DRAIN;
        drain_d = DC_W'(DRAIN_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mc_cnt_q    <= '0;
      drain_q     <= DC_W'(DRAIN_CYCLES);
      ret_drain_q <= 1'b0;
      lu_stall_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      drain_q     <= drain_d;
      ret_drain_q <= ret_drain_d;
      lu_stall_q  <= lu_stall;
    end
  end

  assign stall_inc = !ctrl.pc_en && (state_q != ST_HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exma_en     = ctrl.exma_en;
  assign exma_bubble = ctrl.exma_bubble;
  assign mawb_bubble = ctrl.mawb_bubble;
  assign halt_ack    = ctrl.halt_ack;
  assign state_o     = state_q;

  // A single load-use hazard needs exactly one bubble; back-to-back is a producer bug.
  a_lu_single: assert property (@(posedge clk) disable iff (rst) !(lu_stall_q && lu_stall));
  a_br_mc_excl: assert property (@(posedge clk) disable iff (rst) !(branch_taken && mc_start));

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each driven cycle pushes its expected
// control vector, which is popped and compared against the DUT outputs.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use, branch_taken, mc_start, dmem_wait, halt_req;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exma_en, exma_bubble, mawb_bubble, halt_ack;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  // Input vector: {load_use, branch_taken, mc_start, dmem_wait, halt_req}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_LU   = 5'b10000;
  localparam logic [4:0] I_BR   = 5'b01000;
  localparam logic [4:0] I_MC   = 5'b00100;
  localparam logic [4:0] I_DM   = 5'b00010;
  localparam logic [4:0] I_HALT = 5'b00001;

  // Output vector: {state, halt_ack, pc_en, ifid_en, ifid_flush, idex_en,
  //                 idex_flush, exma_en, exma_bubble, mawb_bubble}
  localparam logic [10:0] E_RUN     = 11'b00_0_1_1_0_1_0_1_0_0;
  localparam logic [10:0] E_STALL   = 11'b00_0_0_0_0_0_0_1_1_0;
  localparam logic [10:0] E_BR      = 11'b00_0_1_1_1_1_1_1_0_0;
  localparam logic [10:0] E_MCSTALL = 11'b01_0_0_0_0_0_0_1_1_0;
  localparam logic [10:0] E_MCREL   = 11'b01_0_1_1_0_1_0_1_0_0;
  localparam logic [10:0] E_DMEM_MC = 11'b01_0_0_0_0_0_0_0_0_1;
  localparam logic [10:0] E_DRAIN   = 11'b10_0_0_1_1_1_0_1_0_0;
  localparam logic [10:0] E_DR_BR   = 11'b10_0_1_1_1_1_1_1_0_0;
  localparam logic [10:0] E_HALT    = 11'b11_1_0_1_1_1_0_1_0_0;

  pipe_stall_ctrl #(.MC_LATENCY(4), .DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mc_start     (mc_start),
    .dmem_wait    (dmem_wait),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exma_en      (exma_en),
    .exma_bubble  (exma_bubble),
    .mawb_bubble  (mawb_bubble),
    .halt_ack     (halt_ack),
    .state_o      (state_o),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [10:0] dut_vec();
    return {state_o, halt_ack, pc_en, ifid_en, ifid_flush, idex_en,
            idex_flush, exma_en, exma_bubble, mawb_bubble};
  endfunction

  // Called at a negedge: drive one cycle of inputs, score the Mealy outputs
  // mid-cycle, then advance through the posedge to the next negedge.
  task automatic step(input string tag, input logic [4:0] ins, input logic [10:0] exp);
    logic [10:0] e;
    string       t;
    {load_use, branch_taken, mc_start, dmem_wait, halt_req} = ins;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 32'(dut_vec()), 32'(e));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {load_use, branch_taken, mc_start, dmem_wait, halt_req} = I_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    step("reset_outputs", I_NONE, E_RUN);

    // Single load-use bubble
    step("lu_stall", I_LU, E_STALL);
    step("lu_after", I_NONE, E_RUN);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Multi-cycle op: three stall cycles then release on the fourth
    step("mc_c0", I_MC, E_STALL);
    step("mc_c1", I_MC, E_MCSTALL);
    step("mc_c2", I_MC, E_MCSTALL);
    step("mc_release", I_MC, E_MCREL);
    step("mc_back_run", I_NONE, E_RUN);
    check("mc_stall_cnt", 32'(stall_cnt), 32'd4);

    // Branch wins over load-use in the same cycle
    step("br_lu", I_BR | I_LU, E_BR);
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd4);

    // Memory wait freezes MC_WAIT with one stall cycle still owed
    step("mcd_c0", I_MC, E_STALL);
    step("mcd_c1", I_MC, E_MCSTALL);
    for (int i = 0; i < 3; i++) step($sformatf("mcd_dmem%0d", i), I_MC | I_DM, E_DMEM_MC);
    step("mcd_last_stall", I_MC, E_MCSTALL);
    step("mcd_release", I_MC, E_MCREL);
    step("mcd_back_run", I_NONE, E_RUN);
    check("mcd_stall_cnt", 32'(stall_cnt), 32'd10);

    // Full halt: accept, four drain advances, park, then resume
    step("halt_accept", I_HALT, E_RUN);
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), I_HALT, E_DRAIN);
    step("halted", I_HALT, E_HALT);
    step("halted_release", I_NONE, E_HALT);
    step("resume_run", I_NONE, E_RUN);
    check("halt_stall_cnt", 32'(stall_cnt), 32'd14);

    // Branch during drain redirects PC; dropping halt_req returns to RUN
    step("dr2_accept", I_HALT, E_RUN);
    step("dr2_branch", I_HALT | I_BR, E_DR_BR);
    step("dr2_abort", I_NONE, E_DRAIN);
    step("dr2_back_run", I_NONE, E_RUN);
    check("dr2_flush_cnt", 32'(flush_cnt), 32'd2);
    check("dr2_stall_cnt", 32'(stall_cnt), 32'd15);

    // Reset in the middle of a drain with two advances left
    step("dr3_accept", I_HALT, E_RUN);
    step("dr3_drain0", I_HALT, E_DRAIN);
    step("dr3_drain1", I_HALT, E_DRAIN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    step("rst_outputs", I_NONE, E_RUN);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core (IF, ID, EX, MA, WB).
- Merges hazard requests into one prioritised set of per-stage enable/flush/bubble controls:
  - load-use stall from the forwarding unit
  - taken branch from EX
  - multi-cycle EX ops
  - data-memory wait
  - external halt/drain
- Sits beside the forwarding unit and drives the PC register and every pipeline register.

Parameters:
- MC_LATENCY, 4: total EX-occupancy cycles of a multi-cycle op; must be >= 2.
- DRAIN_CYCLES, 4: pipeline advances needed to empty ID..WB before halt_ack.
- CNT_W, 16: width of saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_use  in  1  load in EX/MA with dependent consumer in ID/EX
- branch_taken  in  1  taken branch/jump resolved in EX; PC mux already selects target
- mc_start  in  1  multi-cycle op occupies EX (level while in EX)
- dmem_wait  in  1  data memory has not completed the MA access this cycle
- halt_req  in  1  request to drain and park the pipeline (level)
- pc_en  out  1  PC register write enable
- ifid_en  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_en  out  1  ID/EX write enable
- idex_flush  out  1  load NOP into ID/EX
- exma_en  out  1  EX/MA write enable
- exma_bubble  out  1  load NOP into EX/MA
- mawb_bubble  out  1  load NOP into MA/WB
- halt_ack  out  1  pipeline empty and parked
- state_o  out  2  FSM state (debug)
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not HALTED, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- FSM states: RUN=0, MC_WAIT=1, DRAIN=2, HALTED=3.
- Reset values:
  - state=RUN; mc_cnt=0; drain_cnt=DRAIN_CYCLES; ret_drain=0; stall_cnt=0; flush_cnt=0.
  - Outputs (Mealy) with inputs low: all *_en=1, all flush/bubble=0, halt_ack=0.
- Default (no event): all enables 1, flush/bubble 0.
- Priority per cycle, highest first: dmem_wait > MC_WAIT hold > mc_start > branch_taken > load_use > halt_req acceptance.
- dmem_wait (any state except HALTED):
  - pc_en, ifid_en, idex_en, exma_en = 0; mawb_bubble=1.
  - No state change; mc_cnt and drain_cnt hold.
  - Lower-priority inputs ignored; they persist because the stages are frozen.
- mc_start in RUN or DRAIN:
  - pc_en, ifid_en, idex_en = 0; exma_bubble=1.
  - mc_cnt <= MC_LATENCY-2; ret_drain <= (state==DRAIN); go to MC_WAIT.
- MC_WAIT:
  - While mc_cnt != 0: same stall outputs, mc_cnt decrements.
  - At mc_cnt == 0: release cycle, default outputs, next state = DRAIN if ret_drain else RUN.
  - mc_start ignored in MC_WAIT.
  - Net effect: L-1 stall cycles, then release on cycle L.
- branch_taken:
  - pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt++.
  - load_use is ignored the same cycle (its consumer is being flushed).
- load_use:
  - pc_en, ifid_en, idex_en = 0; exma_bubble=1.
  - One cycle per occurrence; load_use high on 2 consecutive advancing cycles is a protocol error (assertion).
- halt_req in RUN, when no higher event is active: go to DRAIN with drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - Outputs: pc_en=0, ifid_flush=1; other stages advance normally.
  - drain_cnt decrements only on cycles with exma_en=1 and no bubble source active.
  - At drain_cnt == 1 with such an advance: go to HALTED.
  - load_use and branch_taken are applied as in RUN, except pc_en=0 unless branch_taken (the target becomes the resume PC).
- HALTED:
  - Outputs: pc_en=0, ifid_flush=1, halt_ack=1.
  - When halt_req=0: go to RUN next cycle; halt_ack drops the same cycle as the transition.
- halt_req deasserted during DRAIN: return to RUN next cycle; no refetch is needed because the PC was held.
- Counters saturate at all-ones, never wrap.
- rst mid-operation aborts any MC_WAIT/DRAIN immediately.
- branch_taken && mc_start simultaneously is illegal (assertion).

Decomposition:
- Shared package core_ctrl_pkg: state encoding, NOP-insert constants, sat-counter width.
- Sub-module sat_counter (CNT_W, inc, clr), instantiated twice for the performance counters.

Test Plan:
- load_use pulse 1 cycle in RUN -> that cycle pc_en=ifid_en=idex_en=0, exma_bubble=1; next cycle defaults; stall_cnt=1.
- mc_start held 4 cycles (MC_LATENCY=4) -> stall on cycles 0,1,2; release on cycle 3; state_o returns 0; stall_cnt=3.
- branch_taken and load_use same cycle -> pc_en=1, ifid_flush=idex_flush=1, exma_bubble=0; flush_cnt=1.
- dmem_wait for 3 cycles during MC_WAIT with mc_cnt=1 -> all en=0, mawb_bubble=1; mc_cnt holds at 1; release 2 cycles after dmem_wait drops.
- halt_req in RUN, no hazards -> 4 DRAIN cycles with pc_en=0, ifid_flush=1; halt_ack=1 on cycle 5; halt_req low -> state_o=0 and halt_ack=0 next cycle.
- rst asserted in DRAIN with drain_cnt=2 -> next cycle state_o=0, counters 0, all enables 1.
